bcd_xs3_serial_codec: RTL and testbench
=======================================

Name: bcd_xs3_serial_codec

Overview:
Bit-serial, LSB-first, bidirectional code converter between 8421 BCD and Excess-3 for a word of NUM_DIGITS digits. It generalises the single-direction serial BCD-to-Excess-3 Mealy converter in three ways: run-time direction select, multi-digit word framing with stall support, and invalid-digit detection. It sits between a serial digit source (keypad/UART deserialiser side) and a serial display/arithmetic consumer.

Parameters:
NUM_DIGITS, 4, BCD digits per word; legal range 1..16; word length is 4*NUM_DIGITS bits.
REG_OUT, 1, 1 = bit_out registered (1-cycle latency); 0 = Mealy output (0 latency), other outputs still registered.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
mode  input  1  0 = BCD->XS3 (add 3 per digit), 1 = XS3->BCD (subtract 3 per digit); sampled on the first bit of each word
bit_in  input  1  serial data, LSB of digit 0 first
bit_valid  input  1  bit_in qualifier; low = stall, all state holds
frame_start  input  1  qualifies bit_in as bit 0 of a new word (only meaningful with bit_valid)
bit_out  output  1  converted serial bit
out_valid  output  1  bit_out qualifier
out_first  output  1  bit_out is bit 0 of a word
digit_err  output  1  one-cycle pulse with the bit_out carrying bit 3 of an illegal digit
word_done  output  1  one-cycle pulse with the bit_out carrying the last bit of a word
word_err  output  1  high with word_done if any digit in that word was illegal

Behaviour:
- Reset: all outputs 0, bit index 0, digit index 0, carry 0, latched mode 0, error accumulator 0.
- Per-digit serial constant add. Constant K is 4'h3 (mode 0) or 4'hD (mode 1, i.e. -3 mod 16), fed LSB first.
- Per accepted bit i: out = bit_in ^ K[i] ^ c; c_next = majority(bit_in, K[i], c).
- Carry is cleared after bit 3 of every digit. There is no inter-digit carry, and the carry out of bit 3 is discarded (mod-16 result).
- Digit FSM states B0, B1, B2, B3, each paired with carry 0/1; B0 always has carry 0. This is equivalent to the 7-state single-digit machine.
- Transitions occur only on cycles with bit_valid=1: B0->B1->B2->B3->B0. Leaving B3 increments the digit index, which wraps at NUM_DIGITS-1 to 0.
- Words may be back-to-back without frame_start. Word boundaries come from the counters.
- frame_start with bit_valid: forces bit index and digit index to 0, clears carry and the error accumulator, and relatches mode. Any partial word is abandoned with no word_done.
- frame_start without bit_valid is ignored.
- Mode changes mid-word are ignored until the next word's bit 0.
- Input nibble captured serially. On bit 3, the digit is illegal if:
  - mode 0: nibble > 9
  - mode 1: nibble < 3 or nibble > 12
- Illegal digits are still converted mod 16 and output. digit_err pulses and the accumulator sets.
- word_err = accumulator OR the current digit's error, presented with word_done.
- REG_OUT=1: bit_out, out_valid, out_first, digit_err, word_done and word_err all appear exactly 1 cycle after the accepted bit.
- During a stall, out_valid=0 and bit_out holds its last value.
- REG_OUT=0: bit_out and out_valid are combinational in the same cycle; flags are still registered, 1 cycle later.
- Reset asserted mid-word: immediate return to reset state. After release, the first accepted bit is bit 0 of a word regardless of frame_start.

Decomposition:
- Shared package bcd_xs3_pkg:
  - MODE_BCD2XS3=1'b0, MODE_XS32BCD=1'b1
  - K_ADD3=4'h3, K_SUB3=4'hD
  - NIBBLE_W=4
  - BCD_MAX=9, XS3_MIN=3, XS3_MAX=12
- One sub-module, xs3_digit_serial_adder: bit-index FSM, carry, constant select, nibble capture and legality check for one digit.
- The top adds the digit counter, framing, error accumulation and output registers.

Test Plan:
- NUM_DIGITS=2, mode 0, word 0x29. Input bits 1,0,0,1,0,1,0,0 -> bit_out 0,0,1,1,1,0,1,0 (0x5C), each 1 cycle later; word_done on the 8th output; word_err=0.
- Mode 1, word 0x5C -> 0x29. Follow with a second back-to-back word 0x33 with no frame_start -> 0x00; out_first on output bits 0 and 8.
- Mode 0, digit 0xB -> output nibble 0xE; digit_err with its bit 3; word_err=1 at word_done. Next word 0x00 -> 0x33 with word_err=0.
- Mode 1, digit 0x1 -> 0xE with digit_err. Mode 1, digit 0xD -> 0xA with digit_err. Mode 1, digits 0x3 and 0xC -> 0x0 and 0x9 with no error.
- Insert random bit_valid=0 gaps and a mode toggle mid-word -> output identical to the gap-free run, with out_valid low in each gap.
- Assert frame_start at digit 1 bit 2: the abandoned word gets no word_done and the new word converts correctly. Assert reset at bit 5: all outputs go 0 in the same cycle, and the next word converts from bit 0.

Source files
------------

// File: rtl/bcd_xs3_serial_codec_pkg.sv
// Shared definitions for the serial BCD <-> Excess-3 codec.
// Holds the mode encodings, per-digit constants, legality limits,
// the digit-bit FSM state type and the digit legality helper.
package bcd_xs3_pkg;
  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;

  localparam logic [3:0] K_ADD3 = 4'h3;
  // -3 mod 16, so one adder serves both directions
  localparam logic [3:0] K_SUB3 = 4'hD;

  localparam int NIBBLE_W = 4;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;

  // Bit position inside the current digit
  typedef enum logic [1:0] {B0, B1, B2, B3} bit_st_e;

  function automatic logic digit_illegal(input logic mode, input logic [NIBBLE_W-1:0] n);
    if (mode == MODE_BCD2XS3) return (n > BCD_MAX);
    else                      return (n < XS3_MIN) || (n > XS3_MAX);
  endfunction
endpackage

// File: rtl/bcd_xs3_serial_codec_if.sv
// Serial stream bundle for the codec.
//   master: serial source / consumer (drives mode, bit_in, bit_valid, frame_start)
//   slave : the codec (drives bit_out, out_valid, out_first, digit_err,
//           word_done, word_err)
interface bcd_xs3_serial_codec_if;
  logic mode;
  logic bit_in;
  logic bit_valid;
  logic frame_start;
  logic bit_out;
  logic out_valid;
  logic out_first;
  logic digit_err;
  logic word_done;
  logic word_err;

  modport master (
    output mode, bit_in, bit_valid, frame_start,
    input  bit_out, out_valid, out_first, digit_err, word_done, word_err
  );

  modport slave (
    input  mode, bit_in, bit_valid, frame_start,
    output bit_out, out_valid, out_first, digit_err, word_done, word_err
  );
endinterface

// File: rtl/bcd_xs3_serial_codec_digit.sv
// xs3_digit_serial_adder: serial add of a 4-bit constant to one digit.
// Ports:
//   clk, reset : clock, async active-high reset
//   i_valid    : bit accepted this cycle (state advances only then)
//   i_clear    : treat this bit as bit 0 with carry 0 (new frame)
//   i_mode     : direction for this digit (selects +3 or -3)
//   i_bit      : serial input bit
//   o_bit      : converted bit (combinational)
//   o_at_b0    : registered position is bit 0
//   o_last     : current bit is bit 3 of the digit
//   o_illegal  : current bit is bit 3 and the captured digit is illegal
module xs3_digit_serial_adder
  import bcd_xs3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic i_clear,
  input  logic i_mode,
  input  logic i_bit,
  output logic o_bit,
  output logic o_at_b0,
  output logic o_last,
  output logic o_illegal
);
  bit_st_e r_state, w_state_nxt, w_idx;
  logic r_carry, w_carry, w_carry_nxt, w_kb;
  logic [2:0] r_nib;
  logic [NIBBLE_W-1:0] w_k, w_nib;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= B0;
      r_carry <= 1'b0;
      r_nib   <= '0;
    end else if (i_valid) begin
      r_state <= w_state_nxt;
      r_carry <= w_carry_nxt;
      r_nib   <= w_nib[2:0];
    end
  end

  always_comb begin
    w_idx       = i_clear ? B0 : r_state;
    w_carry     = i_clear ? 1'b0 : r_carry;
    w_k         = (i_mode == MODE_XS32BCD) ? K_SUB3 : K_ADD3;
    w_kb        = w_k[w_idx];
    o_bit       = i_bit ^ w_kb ^ w_carry;
    o_last      = (w_idx == B3);
    // carry out of bit 3 is dropped: result is mod 16, no inter-digit carry
    w_carry_nxt = o_last ? 1'b0
                         : ((i_bit & w_kb) | (i_bit & w_carry) | (w_kb & w_carry));
    // nibble as seen with the current bit slotted in
    w_nib        = {1'b0, r_nib};
    w_nib[w_idx] = i_bit;
    o_illegal   = o_last && digit_illegal(i_mode, w_nib);
    o_at_b0     = (r_state == B0);
    w_state_nxt = B0;
    case (w_idx)
      B0: w_state_nxt = B1;
      B1: w_state_nxt = B2;
      B2: w_state_nxt = B3;
      B3: w_state_nxt = B0;
      default: w_state_nxt = B0;
    endcase
  end
endmodule

// File: rtl/bcd_xs3_serial_codec.sv
// bcd_xs3_serial_codec: bit-serial LSB-first BCD <-> Excess-3 converter
// for words of NUM_DIGITS digits.
// Ports:
//   clk, reset : clock, async active-high reset
//   io (slave) : mode, bit_in, bit_valid, frame_start in;
//                bit_out, out_valid, out_first, digit_err, word_done,
//                word_err out
// REG_OUT=1 registers bit_out/out_valid (1-cycle latency); REG_OUT=0
// presents them combinationally. Flags are always registered.
module bcd_xs3_serial_codec
  import bcd_xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit REG_OUT    = 1'b1
) (
  input logic clk,
  input logic reset,
  bcd_xs3_serial_codec_if.slave io
);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  logic [DW-1:0] r_digit, w_digit;
  logic r_mode, r_acc;
  logic r_bit_out, r_out_valid, r_first, r_derr, r_wdone, r_werr;
  logic w_start, w_first, w_mode, w_acc, w_bit, w_at_b0, w_last, w_ill, w_word_end;

  // frame_start only counts when it qualifies an accepted bit
  assign w_start    = io.bit_valid & io.frame_start;
  assign w_digit    = w_start ? '0 : r_digit;
  assign w_first    = w_start | (w_at_b0 && (r_digit == '0));
  // mode is only sampled on bit 0 of a word
  assign w_mode     = w_first ? io.mode : r_mode;
  assign w_acc      = w_start ? 1'b0 : r_acc;
  assign w_word_end = w_last && (w_digit == LAST_DIGIT);

  xs3_digit_serial_adder u_digit (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (io.bit_valid),
    .i_clear   (w_start),
    .i_mode    (w_mode),
    .i_bit     (io.bit_in),
    .o_bit     (w_bit),
    .o_at_b0   (w_at_b0),
    .o_last    (w_last),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit     <= '0;
      r_mode      <= MODE_BCD2XS3;
      r_acc       <= 1'b0;
      r_bit_out   <= 1'b0;
      r_out_valid <= 1'b0;
      r_first     <= 1'b0;
      r_derr      <= 1'b0;
      r_wdone     <= 1'b0;
      r_werr      <= 1'b0;
    end else begin
      r_out_valid <= io.bit_valid;
      r_first     <= io.bit_valid & w_first;
      r_derr      <= io.bit_valid & w_ill;
      r_wdone     <= io.bit_valid & w_word_end;
      r_werr      <= io.bit_valid & w_word_end & (w_acc | w_ill);
      if (io.bit_valid) begin
        r_mode    <= w_mode;
        r_bit_out <= w_bit;
        if (w_last) r_digit <= (w_digit == LAST_DIGIT) ? '0 : w_digit + 1'b1;
        else        r_digit <= w_digit;
        // accumulator restarts for each back-to-back word
        r_acc     <= w_word_end ? 1'b0 : (w_acc | w_ill);
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      assign io.bit_out   = r_bit_out;
      assign io.out_valid = r_out_valid;
    end else begin : g_mealy_out
      // r_bit_out holds the last converted bit across stalls
      assign io.bit_out   = (io.bit_valid & ~reset) ? w_bit : r_bit_out;
      assign io.out_valid = io.bit_valid & ~reset;
    end
  endgenerate

  assign io.out_first = r_first;
  assign io.digit_err = r_derr;
  assign io.word_done = r_wdone;
  assign io.word_err  = r_werr;
endmodule

// File: tb/tb_bcd_xs3_serial_codec.sv
// Self-checking bench for bcd_xs3_serial_codec (NUM_DIGITS=2, REG_OUT=1).
// Word vectors with hand-derived outputs feed a scoreboard queue; a negedge
// monitor pops and compares each valid output bit and its flags.
module tb_bcd_xs3_serial_codec;
  localparam int ND = 2;
  localparam int WB = 4 * ND;

  typedef struct {
    logic b, first, derr, wdone, werr;
  } exp_t;

  typedef struct {
    logic       md;
    logic       fs;
    logic [7:0] w;
    logic [7:0] ew;
    logic [1:0] emask;
    logic       ewerr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic exp_v = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[10];
  vec_t gv, gv2, pv, rv;

  always #5 clk = ~clk;

  bcd_xs3_serial_codec_if ifc ();

  bcd_xs3_serial_codec #(.NUM_DIGITS(ND), .REG_OUT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (ifc)
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // output is valid exactly one cycle after an accepted input bit
  always @(posedge clk) exp_v <= reset ? 1'b0 : ifc.bit_valid;

  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", ifc.out_valid, exp_v);
    if (ifc.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got bit %b expected none at %0t", ifc.bit_out, $time);
      end else begin
        e = sb.pop_front();
        chk("bit_out",   ifc.bit_out,   e.b);
        chk("out_first", ifc.out_first, e.first);
        chk("digit_err", ifc.digit_err, e.derr);
        chk("word_done", ifc.word_done, e.wdone);
        chk("word_err",  ifc.word_err,  e.werr);
      end
    end
  end

  task automatic drive(input logic b, input logic fs, input logic md, input logic v);
    @(negedge clk);
    ifc.bit_in      = b;
    ifc.frame_start = fs;
    ifc.mode        = md;
    ifc.bit_valid   = v;
  endtask

  // stall cycle with junk data; frame_start here must be ignored
  task automatic idle();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send_word(input vec_t v, input int nbits, input bit gaps, input bit toggle);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.b     = v.ew[i];
      e.first = (i == 0);
      e.derr  = ((i % 4) == 3) && v.emask[i / 4];
      e.wdone = (i == WB - 1);
      e.werr  = (i == WB - 1) && v.ewerr;
      sb.push_back(e);
      if (gaps) repeat ($urandom_range(2, 0)) idle();
      drive(v.w[i], v.fs && (i == 0), (toggle && i > 0) ? ~v.md : v.md, 1'b1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bit_out"},   ifc.bit_out,   1'b0);
    chk({tag, "_out_valid"}, ifc.out_valid, 1'b0);
    chk({tag, "_out_first"}, ifc.out_first, 1'b0);
    chk({tag, "_digit_err"}, ifc.digit_err, 1'b0);
    chk({tag, "_word_done"}, ifc.word_done, 1'b0);
    chk({tag, "_word_err"},  ifc.word_err,  1'b0);
  endtask

  initial begin
    // {mode, frame_start, input word, expected word, digit_err mask, word_err}
    vecs[0] = '{1'b0, 1'b1, 8'h29, 8'h5C, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h5C, 8'h29, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h0B, 8'h3E, 2'b01, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h33, 2'b00, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'h31, 8'h0E, 2'b01, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'hD3, 8'hA0, 2'b10, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'hC3, 8'h90, 2'b00, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h99, 8'hCC, 2'b00, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 8'hF0, 8'h23, 2'b10, 1'b1};
    gv  = '{1'b0, 1'b1, 8'h47, 8'h7A, 2'b00, 1'b0};
    gv2 = '{1'b1, 1'b1, 8'h7A, 8'h47, 2'b00, 1'b0};
    pv  = '{1'b0, 1'b1, 8'h29, 8'h5C, 2'b00, 1'b0};
    rv  = '{1'b0, 1'b0, 8'h29, 8'h5C, 2'b00, 1'b0};

    ifc.bit_in = 1'b0; ifc.frame_start = 1'b0; ifc.mode = 1'b0; ifc.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    idle();

    // back-to-back words straight from the table
    for (int i = 0; i < 10; i++) send_word(vecs[i], WB, 1'b0, 1'b0);
    repeat (2) idle();

    // gap-free reference, then random stalls plus a mid-word mode flip
    send_word(gv, WB, 1'b0, 1'b0);
    send_word(gv, WB, 1'b1, 1'b1);
    send_word(gv2, WB, 1'b1, 1'b1);
    repeat (2) idle();

    // abandon a word at digit 1 bit 2 with a new frame_start
    send_word(pv, 6, 1'b0, 1'b0);
    send_word(pv, WB, 1'b0, 1'b0);
    repeat (2) idle();

    // reset at bit 5, then a word with no frame_start
    send_word(pv, 5, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    ifc.bit_valid = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    send_word(rv, WB, 1'b0, 1'b0);
    repeat (3) idle();

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
